regfile: RTL
============

Name: regfile

Overview:
- Integer register file that terminates the writeback stage's register-write interface and sources operands for the decode-to-execute pipeline register.
- Accepts one write per cycle: data, enable, address.
- Provides two bypassed read ports whose results are captured into ID/EX operand registers, with stall (keep) and bubble (nop) control.
- Provides a debug read port and a committed-write counter for verification.

Parameters:
- XLEN, 32: register and data width.
- SP_INIT, 32'h0000_0000: reset value of x2 (stack pointer).
- CNT_W, 32: width of write_count.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-low reset.
- keep  input  1  hold ID/EX operand registers (pipeline stall).
- nop  input  1  load zeros into ID/EX operand registers (bubble).
- read_addr1  input  5  rs1 index from decode.
- read_addr2  input  5  rs2 index from decode.
- Regwrite  input  1  write enable from writeback, active-high.
- write_reg_address  input  5  destination index from writeback.
- write_reg_data  input  XLEN  write data from writeback.
- rs1_data_pype1  output  XLEN  registered rs1 operand for execute.
- rs2_data_pype1  output  XLEN  registered rs2 operand for execute.
- dbg_addr  input  5  debug read index.
- dbg_data  output  XLEN  debug read data, combinational, no bypass.
- write_count  output  CNT_W  number of committed writes since reset.

Behaviour:
- Reset is sampled only on the rising edge of clk when rst=0.
- Reset clears x1 and x3..x31 to 0 and sets x2=SP_INIT.
- Reset clears rs1_data_pype1, rs2_data_pype1 and write_count to 0.
- Reset has priority over everything. A write presented in the reset cycle is discarded and write_count is not incremented.
- x0 reads as 0 always and is never stored. Implementation holds no flops for x0.
- Commit condition: rst=1 & Regwrite=1 & write_reg_address!=0. On commit, at the clock edge:
  - reg[write_reg_address] <= write_reg_data.
  - write_count <= write_count+1, wrapping modulo 2^CNT_W.
- Writes commit regardless of keep and nop; retirement is never stalled by decode.
- Bypassed read, combinational, per port n:
  - If read_addrn==0, value = 0.
  - Else if Regwrite=1 & write_reg_address==read_addrn, value = write_reg_data (write-first).
  - Else value = reg[read_addrn].
- Operand register update at the clock edge, priority order:
  1. rst=0 -> 0.
  2. keep=1 -> hold the current value.
  3. nop=1 -> 0.
  4. Otherwise -> the bypassed read value.
- keep dominates nop when both are asserted.
- Read-to-operand latency is 1 cycle. Write-to-read latency through bypass is 0 cycles: a value written in cycle N is visible in the operand captured at the end of cycle N.
- While keep=1 and a write targets a held operand's index, the held operand is not refreshed. The first non-keep cycle captures the updated value from the array or bypass.
- Both ports reading the same index return identical values. Both may bypass in the same cycle.
- dbg_data = 0 if dbg_addr==0, else reg[dbg_addr] (array contents only, before this cycle's write).
- If reset is asserted mid-operation, all state returns to reset values in one cycle. There is no multi-cycle init sequence.

Test Plan:
- Reset, SP_INIT=32'h0001_0000: hold rst=0 one edge, release -> dbg_addr=2 gives 32'h0001_0000; dbg_addr=5 gives 0; operands 0; write_count=0.
- Write then read: write x5=32'hDEAD_BEEF in cycle N, read_addr1=5 in cycle N+1 -> rs1_data_pype1=32'hDEAD_BEEF after edge N+1; write_count=1.
- Same-cycle bypass: in one cycle, Regwrite=1, write_reg_address=7, write_reg_data=32'h1234_5678, read_addr1=read_addr2=7 -> both operands 32'h1234_5678 after that edge; dbg_addr=7 showed the old value (0) during that cycle.
- x0 protection: Regwrite=1, write_reg_address=0, write_reg_data=32'hFFFF_FFFF -> read_addr1=0 yields 0; write_count unchanged.
- keep/nop: operands hold A,B. Assert keep with nop=1 and a write to rs1's index -> operands stay A,B. Deassert keep with nop=1 -> operands 0. Then nop=0 -> operands capture the new written value.
- Counter wrap (CNT_W=4): perform 17 commits -> write_count=1. Then a write during rst=0 -> write_count=0 and the target register is reset-valued.

Source files
------------

// File: rtl/regfile.sv
// Integer register file: one write port from writeback, two write-first bypassed
// read ports captured into ID/EX operand registers, plus debug read and write counter.
module regfile #(
    parameter int              XLEN    = 32,
    parameter logic [XLEN-1:0] SP_INIT = '0,
    parameter int              CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              keep,
    input  logic              nop,
    input  logic [4:0]        read_addr1,
    input  logic [4:0]        read_addr2,
    input  logic              Regwrite,
    input  logic [4:0]        write_reg_address,
    input  logic [XLEN-1:0]   write_reg_data,
    output logic [XLEN-1:0]   rs1_data_pype1,
    output logic [XLEN-1:0]   rs2_data_pype1,
    input  logic [4:0]        dbg_addr,
    output logic [XLEN-1:0]   dbg_data,
    output logic [CNT_W-1:0]  write_count
);

    // x0 is hard-wired zero, so storage starts at x1.
    logic [XLEN-1:0]  regs_q [1:31];
    logic [XLEN-1:0]  regs_d [1:31];
    logic [XLEN-1:0]  rs1_q, rs1_d;
    logic [XLEN-1:0]  rs2_q, rs2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  rd1, rd2;
    logic             commit;

    always_comb begin
        commit = Regwrite && (write_reg_address != 5'd0);

        regs_d = regs_q;
        if (commit) begin
            regs_d[write_reg_address] = write_reg_data;
        end
        cnt_d = commit ? cnt_q + CNT_W'(1) : cnt_q;

        // Write-first bypass: an operand read in the same cycle as a write sees the new data.
        rd1 = '0;
        if (read_addr1 != 5'd0) begin
            if (Regwrite && (write_reg_address == read_addr1)) rd1 = write_reg_data;
            else                                              rd1 = regs_q[read_addr1];
        end
        rd2 = '0;
        if (read_addr2 != 5'd0) begin
            if (Regwrite && (write_reg_address == read_addr2)) rd2 = write_reg_data;
            else                                              rd2 = regs_q[read_addr2];
        end

        // keep outranks nop so a stalled bubble is not lost.
        if (keep) begin
            rs1_d = rs1_q;
            rs2_d = rs2_q;
        end else if (nop) begin
            rs1_d = '0;
            rs2_d = '0;
        end else begin
            rs1_d = rd1;
            rs2_d = rd2;
        end

        dbg_data = '0;
        if (dbg_addr != 5'd0) begin
            dbg_data = regs_q[dbg_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= (i == 2) ? SP_INIT : '0;
            end
            rs1_q <= '0;
            rs2_q <= '0;
            cnt_q <= '0;
        end else begin
            regs_q <= regs_d;
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
            cnt_q  <= cnt_d;
        end
    end

    assign rs1_data_pype1 = rs1_q;
    assign rs2_data_pype1 = rs2_q;
    assign write_count    = cnt_q;

endmodule
